// File: rtl/wordle_pkg.sv
// rtl/wordle_pkg.sv - shared defaults, colour codes and scorer state enum for the wordle guess scorer
package wordle_pkg;

  localparam int WORDLE_NUM_LETTERS = 5;
  localparam int WORDLE_LETTER_W    = 8;

  localparam logic [2:0] COLOR_GREEN  = 3'b010;
  localparam logic [2:0] COLOR_YELLOW = 3'b110;
  localparam logic [2:0] COLOR_WHITE  = 3'b111;
  localparam logic [2:0] COLOR_BLANK  = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    GREEN,
    YELLOW,
    DONE
  } scorer_state_t;

endpackage

// File: rtl/wordle_guess_scorer_if.sv
// rtl/wordle_guess_scorer_if.sv - request/result bundle between a game controller and the guess scorer
interface wordle_guess_scorer_if #(
  parameter int NUM_LETTERS = 5,
  parameter int LETTER_W    = 8
);
  logic                            start;
  logic [NUM_LETTERS*LETTER_W-1:0] guess;
  logic [NUM_LETTERS*LETTER_W-1:0] answer;
  logic                            busy;
  logic                            done;
  logic [NUM_LETTERS*3-1:0]        colors;
  logic                            win;

  modport master (
    output start, guess, answer,
    input  busy, done, colors, win
  );

  modport slave (
    input  start, guess, answer,
    output busy, done, colors, win
  );
endinterface

// File: rtl/wordle_letter_match.sv
// rtl/wordle_letter_match.sv - finds the lowest-index unused answer position holding a given letter
module wordle_letter_match
  import wordle_pkg::*;
#(
  parameter int NUM_LETTERS = WORDLE_NUM_LETTERS,
  parameter int LETTER_W    = WORDLE_LETTER_W
) (
  input  logic [LETTER_W-1:0]             letter,
  input  logic [NUM_LETTERS*LETTER_W-1:0] answer,
  input  logic [NUM_LETTERS-1:0]          used,
  output logic                            found,
  output logic [NUM_LETTERS-1:0]          position
);

  // Scan from the highest position down so the lowest match is the last one written.
  always_comb begin
    found    = 1'b0;
    position = '0;
    for (int i = NUM_LETTERS - 1; i >= 0; i--) begin
      if (!used[i] && (answer[(NUM_LETTERS-1-i)*LETTER_W +: LETTER_W] == letter)) begin
        found       = 1'b1;
        position    = '0;
        position[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wordle_guess_scorer.sv
// rtl/wordle_guess_scorer.sv - sequential wordle scorer: green pass, then yellow/white pass, one letter per cycle
// Optional build macro WORDLE_SCORER_DUP_EN enables duplicate-aware yellow scoring.
module wordle_guess_scorer
  import wordle_pkg::*;
#(
  parameter int NUM_LETTERS = WORDLE_NUM_LETTERS,
  parameter int LETTER_W    = WORDLE_LETTER_W
) (
  input  logic                  Clk,
  input  logic                  reset,
  wordle_guess_scorer_if.slave  bus
);

  localparam int IDX_W = (NUM_LETTERS > 1) ? $clog2(NUM_LETTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LETTERS - 1);

  scorer_state_t                   state;
  logic [IDX_W-1:0]                idx;
  logic [NUM_LETTERS*LETTER_W-1:0] guess_q;
  logic [NUM_LETTERS*LETTER_W-1:0] answer_q;
  logic [2:0]                      color_q [NUM_LETTERS];
  logic                            busy_q;
  logic                            done_q;
  logic                            win_q;

  logic [LETTER_W-1:0]             guess_l  [NUM_LETTERS];
  logic [LETTER_W-1:0]             answer_l [NUM_LETTERS];
  logic [NUM_LETTERS*3-1:0]        colors_flat;
  logic                            all_green;
  logic [NUM_LETTERS-1:0]          used_mask;
  logic                            match_found;
  logic [NUM_LETTERS-1:0]          match_onehot;

`ifdef WORDLE_SCORER_DUP_EN
  logic [NUM_LETTERS-1:0]          used_q;
  assign used_mask = used_q;
`else
  // Without duplicate handling any occurrence of the letter counts, so the matcher sees nothing used.
  logic                            unused_onehot;
  assign used_mask     = '0;
  assign unused_onehot = ^match_onehot;
`endif

  for (genvar i = 0; i < NUM_LETTERS; i++) begin : g_letter
    assign guess_l[i]  = guess_q[(NUM_LETTERS-1-i)*LETTER_W +: LETTER_W];
    assign answer_l[i] = answer_q[(NUM_LETTERS-1-i)*LETTER_W +: LETTER_W];
  end

  always_comb begin
    colors_flat = '0;
    all_green   = 1'b1;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      colors_flat[(NUM_LETTERS-1-i)*3 +: 3] = color_q[i];
      if (color_q[i] != COLOR_GREEN) all_green = 1'b0;
    end
  end

  wordle_letter_match #(
    .NUM_LETTERS (NUM_LETTERS),
    .LETTER_W    (LETTER_W)
  ) u_match (
    .letter   (guess_l[idx]),
    .answer   (answer_q),
    .used     (used_mask),
    .found    (match_found),
    .position (match_onehot)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      guess_q  <= '0;
      answer_q <= '0;
      for (int i = 0; i < NUM_LETTERS; i++) color_q[i] <= COLOR_BLANK;
`ifdef WORDLE_SCORER_DUP_EN
      used_q   <= '0;
`endif
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            guess_q  <= bus.guess;
            answer_q <= bus.answer;
            for (int i = 0; i < NUM_LETTERS; i++) color_q[i] <= COLOR_BLANK;
`ifdef WORDLE_SCORER_DUP_EN
            used_q   <= '0;
`endif
            win_q    <= 1'b0;
            idx      <= '0;
            busy_q   <= 1'b1;
            state    <= GREEN;
          end
        end
        GREEN: begin
          if (guess_l[idx] == answer_l[idx]) begin
            color_q[idx] <= COLOR_GREEN;
`ifdef WORDLE_SCORER_DUP_EN
            used_q[idx]  <= 1'b1;
`endif
          end
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= YELLOW;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        YELLOW: begin
          if (color_q[idx] != COLOR_GREEN) begin
            if (match_found) begin
              color_q[idx] <= COLOR_YELLOW;
`ifdef WORDLE_SCORER_DUP_EN
              used_q       <= used_q | match_onehot;
`endif
            end else begin
              color_q[idx] <= COLOR_WHITE;
            end
          end
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          win_q  <= all_green;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.colors = colors_flat;
  assign bus.win    = win_q;

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// tb/tb_wordle_guess_scorer.sv - directed self-checking bench for wordle_guess_scorer
module tb_wordle_guess_scorer;

  logic Clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  wordle_guess_scorer_if #(.NUM_LETTERS(5), .LETTER_W(8)) bus ();

  wordle_guess_scorer #(.NUM_LETTERS(5), .LETTER_W(8)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts one scoring run and watches 20 cycles after the accepting edge.
  task automatic run_score(input logic [39:0] g, input logic [39:0] a,
                           input int restart_at, input logic [39:0] restart_g,
                           input logic change_guess,
                           output int lat, output int ndone, output logic busy_k1);
    @(negedge Clk);
    bus.guess  = g;
    bus.answer = a;
    bus.start  = 1'b1;
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
    if (change_guess) bus.guess = "ZZZZZ";
    lat     = -1;
    ndone   = 0;
    busy_k1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk);
      #1;
      if (k == 1) busy_k1 = bus.busy;
      if (bus.done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (k == restart_at) begin
        bus.start = 1'b1;
        bus.guess = restart_g;
      end else if (k == restart_at + 1) begin
        bus.start = 1'b0;
      end
    end
  endtask

  localparam logic [14:0] ALL_GREEN = {5{3'b010}};
  localparam logic [14:0] ALL_WHITE = {5{3'b111}};
  localparam logic [14:0] NACRE_EXP = {3'b110, 3'b110, 3'b110, 3'b110, 3'b010};
`ifdef WORDLE_SCORER_DUP_EN
  localparam logic [14:0] BOBBY_EXP = {3'b110, 3'b111, 3'b010, 3'b111, 3'b010};
  localparam logic [14:0] EERIE_EXP = {3'b110, 3'b110, 3'b111, 3'b111, 3'b111};
`else
  localparam logic [14:0] BOBBY_EXP = {3'b110, 3'b111, 3'b010, 3'b110, 3'b010};
  localparam logic [14:0] EERIE_EXP = {3'b110, 3'b110, 3'b111, 3'b111, 3'b110};
`endif

  initial begin
    int   lat;
    int   ndone;
    logic bk1;
    int   dcount;

    n_checks   = 0;
    n_fails    = 0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.guess  = '0;
    bus.answer = '0;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst_busy",   bus.busy,   0);
    check_eq("rst_done",   bus.done,   0);
    check_eq("rst_win",    bus.win,    0);
    check_eq("rst_colors", bus.colors, 0);
    @(negedge Clk);
    reset = 1'b1;

    run_score("CRANE", "CRANE", -5, "AAAAA", 1'b0, lat, ndone, bk1);
    check_eq("crane_busy_k1", bk1,        1);
    check_eq("crane_latency", lat,        11);
    check_eq("crane_ndone",   ndone,      1);
    check_eq("crane_colors",  bus.colors, ALL_GREEN);
    check_eq("crane_win",     bus.win,    1);
    check_eq("crane_busy_end", bus.busy,  0);

    run_score("NACRE", "CRANE", -5, "AAAAA", 1'b0, lat, ndone, bk1);
    check_eq("nacre_colors",  bus.colors, NACRE_EXP);
    check_eq("nacre_win",     bus.win,    0);
    check_eq("nacre_latency", lat,        11);

    run_score("BOBBY", "ABBEY", -5, "AAAAA", 1'b0, lat, ndone, bk1);
    check_eq("bobby_colors",  bus.colors, BOBBY_EXP);
    check_eq("bobby_win",     bus.win,    0);

    run_score("EERIE", "SPEED", -5, "AAAAA", 1'b0, lat, ndone, bk1);
    check_eq("eerie_colors",  bus.colors, EERIE_EXP);

    run_score("crane", "CRANE", -5, "AAAAA", 1'b0, lat, ndone, bk1);
    check_eq("case_colors",   bus.colors, ALL_WHITE);
    check_eq("case_win",      bus.win,    0);

    run_score("NACRE", "CRANE", 4, "CRANE", 1'b0, lat, ndone, bk1);
    check_eq("restart_ndone",   ndone,      1);
    check_eq("restart_latency", lat,        11);
    check_eq("restart_colors",  bus.colors, NACRE_EXP);
    check_eq("restart_win",     bus.win,    0);

    run_score("CRANE", "CRANE", -5, "AAAAA", 1'b1, lat, ndone, bk1);
    check_eq("latch_colors",  bus.colors, ALL_GREEN);
    check_eq("latch_win",     bus.win,    1);

    // Abort mid-run with reset.
    @(negedge Clk);
    bus.guess  = "NACRE";
    bus.answer = "CRANE";
    bus.start  = 1'b1;
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("abort_busy",   bus.busy,   0);
    check_eq("abort_colors", bus.colors, 0);
    check_eq("abort_done",   bus.done,   0);
    check_eq("abort_win",    bus.win,    0);
    dcount = 0;
    repeat (3) begin
      @(posedge Clk);
      #1;
      if (bus.done) dcount++;
    end
    @(negedge Clk);
    reset = 1'b1;
    repeat (15) begin
      @(posedge Clk);
      #1;
      if (bus.done) dcount++;
    end
    check_eq("abort_no_done", dcount, 0);

    run_score("CRANE", "CRANE", -5, "AAAAA", 1'b0, lat, ndone, bk1);
    check_eq("post_rst_latency", lat,        11);
    check_eq("post_rst_colors",  bus.colors, ALL_GREEN);
    check_eq("post_rst_win",     bus.win,    1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/wordle_guess_scorer.md
WORDLE_GUESS_SCORER -- requirements
Module: wordle_guess_scorer

Interface
REQ-001 Parameter NUM_LETTERS, default 5, letters per word.
REQ-002 Parameter LETTER_W, default 8, bits per letter (ASCII).
REQ-003 Clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted low clears all state immediately.
REQ-005 start  input  1  request to score; sampled on rising Clk.
REQ-006 guess  input  NUM_LETTERS*LETTER_W  submitted guess; letter 0 in MSBs.
REQ-007 answer  input  NUM_LETTERS*LETTER_W  secret word; same packing.
REQ-008 busy  output  1  high while scoring is in progress.
REQ-009 done  output  1  single-cycle pulse; colors and win are valid from this cycle.
REQ-010 colors  output  NUM_LETTERS*3  per-letter {R,G,B} block colour; letter 0 in MSBs.
REQ-011 win  output  1  high when every letter scores green.

Function
REQ-012 The FSM SHALL have states IDLE, GREEN, YELLOW and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch guess and answer, clear colors to 0, clear used flags, clear win, set idx=0 and enter GREEN.
REQ-014 GREEN SHALL last NUM_LETTERS cycles, one letter per cycle (idx 0..4).
  - Letter equal to answer at idx: colour 3'b010 (green) and answer position idx marked used.
REQ-015 YELLOW SHALL last NUM_LETTERS cycles with idx 0..4.
  - Non-green letter: sets the lowest-index unused, non-green answer position holding the same letter to used and gets colour 3'b110 (yellow).
  - Otherwise: colour 3'b111 (white).
  - Green letters are unchanged.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 done SHALL rise exactly 2*NUM_LETTERS+1 (11) cycles after the edge that samples start.
REQ-018 busy SHALL be high in GREEN, YELLOW and DONE, and low in IDLE.
REQ-019 colors and win SHALL hold their values from DONE until the next accepted start.
REQ-020 start while busy=1 SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-021 Changes on guess/answer after start is accepted SHALL NOT affect the result.
REQ-022 win SHALL equal the AND of all per-letter green results and SHALL be updated in DONE.
REQ-023 Letters SHALL be compared as raw LETTER_W-bit values, with no case folding.

Reset
REQ-024 On reset low:
  - state = IDLE; busy, done and win = 0; colors = 0; used flags and idx = 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation, and no done pulse SHALL be produced.
REQ-026 The first start after reset release SHALL be accepted normally.

Configuration
REQ-027 Macro WORDLE_SCORER_DUP_EN SHALL select duplicate handling.
  - Defined: exact duplicate-aware yellow rule per REQ-015.
  - Undefined: YELLOW marks a non-green letter yellow if it equals any answer letter, ignoring used flags; the used-flag logic is removed.
REQ-028 Latency and the interface SHALL be identical in both builds.

Structure
REQ-029 Package wordle_pkg SHALL hold:
  - NUM_LETTERS and LETTER_W defaults;
  - colour constants COLOR_GREEN=3'b010, COLOR_YELLOW=3'b110, COLOR_WHITE=3'b111, COLOR_BLANK=3'b000;
  - the scorer state enum.
REQ-030 Sub-module wordle_letter_match SHALL be combinational.
  - Inputs: one letter, answer, used mask.
  - Outputs: found and a one-hot position of the lowest matching unused answer letter.
  - Instantiated once and shared across YELLOW cycles.

Verification
REQ-031 answer "CRANE", guess "CRANE" -> colors all 010, win=1, done pulse 11 cycles after start.
REQ-032 answer "CRANE", guess "NACRE" -> colors 110,110,110,110,010; win=0.
REQ-033 answer "ABBEY", guess "BOBBY" with DUP_EN -> 110,111,010,111,010; without DUP_EN -> 110,111,010,110,010.
REQ-034 start pulsed again at cycle 4 of an operation -> ignored; exactly one done; result matches the first guess.
REQ-035 reset low at cycle 6 of an operation -> busy=0, colors=0, no done; a subsequent start with "CRANE"/"CRANE" scores correctly.
REQ-036 guess input changed to "ZZZZZ" one cycle after start is accepted -> result reflects the latched guess only.
